rr_mux_arbiter: RTL and testbench

- Shares one 4:1 multiplexed output channel between four requesters.
- Each requester has a valid/ready handshake, a WIDTH-bit data beat and a last flag.
- A round-robin scheduler with packet locking picks the winner. The winner's index drives the mux select, and the selected beat is captured into a registered output stage.
- Sits in front of any single-consumer resource fed by the existing 4:1 mux datapath.

---
 rtl/rr_mux_arbiter_if.sv | 24 ++
 rtl/rr_mux_arbiter.sv | 125 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between four requesters, the round-robin arbiter and the single consumer.
interface rr_mux_arbiter_if #(
   parameter int WIDTH = 4
);
   logic [3:0]         req_valid;
   logic [4*WIDTH-1:0] req_data;
   logic [3:0]         req_last;
   logic [3:0]         req_ready;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_last;
   logic [1:0]         out_sel;

   modport master (
      output req_valid, req_data, req_last, out_ready,
      input  req_ready, out_valid, out_data, out_last, out_sel
   );

   modport slave (
      input  req_valid, req_data, req_last, out_ready,
      output req_ready, out_valid, out_data, out_last, out_sel
   );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin 4:1 arbiter with packet locking feeding a single registered output beat.
module rr_mux_arbiter #(
   parameter int WIDTH = 4
) (
   input logic           clk,
   input logic           rst_n,
   rr_mux_arbiter_if.slave bus
);
   typedef enum logic [0:0] {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

   state_t             state_r, state_nxt_s;
   logic [1:0]         ptr_r, ptr_nxt_s;
   logic [1:0]         lock_idx_r, lock_idx_nxt_s;
   logic               out_valid_r;
   logic [WIDTH-1:0]   out_data_r;
   logic               out_last_r;
   logic [1:0]         out_sel_r;

   logic               win_found_s;
   logic [1:0]         win_idx_s;
   logic [1:0]         cand_s;
   logic               accept_en_s;
   logic               xfer_s;
   logic [3:0]         req_ready_s;
   logic [WIDTH-1:0]   win_data_s;
   logic               win_last_s;

   // Scheduler state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_ARB;
         ptr_r      <= 2'd0;
         lock_idx_r <= 2'd0;
      end else begin
         state_r    <= state_nxt_s;
         ptr_r      <= ptr_nxt_s;
         lock_idx_r <= lock_idx_nxt_s;
      end
   end

   // Next-state: lock on a non-last beat, rotate the pointer past the packet owner on its last beat.
   always_comb begin
      state_nxt_s    = state_r;
      ptr_nxt_s      = ptr_r;
      lock_idx_nxt_s = lock_idx_r;
      if (xfer_s) begin
         case (state_r)
            ST_ARB: begin
               if (win_last_s) begin
                  ptr_nxt_s = win_idx_s + 2'd1;
               end else begin
                  state_nxt_s    = ST_LOCK;
                  lock_idx_nxt_s = win_idx_s;
               end
            end
            ST_LOCK: begin
               if (win_last_s) begin
                  state_nxt_s = ST_ARB;
                  ptr_nxt_s   = lock_idx_r + 2'd1;
               end else begin
                  state_nxt_s = ST_LOCK;
               end
            end
            default: begin
               state_nxt_s = ST_ARB;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Winner selection and ready generation; a locked channel only ever serves its owner.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = 2'd0;
      cand_s      = 2'd0;
      if (state_r == ST_LOCK) begin
         if (bus.req_valid[lock_idx_r]) begin
            win_found_s = 1'b1;
            win_idx_s   = lock_idx_r;
         end else begin
            win_found_s = 1'b0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            cand_s = ptr_r + 2'(k);
            if (!win_found_s && bus.req_valid[cand_s]) begin
               win_found_s = 1'b1;
               win_idx_s   = cand_s;
            end else begin
               win_found_s = win_found_s;
            end
         end
      end
      accept_en_s = !out_valid_r || bus.out_ready;
      xfer_s      = accept_en_s && win_found_s;
      req_ready_s = xfer_s ? (4'b0001 << win_idx_s) : 4'b0000;
      win_data_s  = bus.req_data[win_idx_s*WIDTH +: WIDTH];
      win_last_s  = bus.req_last[win_idx_s];
   end

   // Output stage: refill on transfer, otherwise clear valid when drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_last_r  <= 1'b0;
         out_sel_r   <= 2'd0;
      end else if (xfer_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= win_data_s;
         out_last_r  <= win_last_s;
         out_sel_r   <= win_idx_s;
      end else if (bus.out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_last  = out_last_r;
   assign bus.out_sel   = out_sel_r;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: tasks push expected beats on grant, a monitor pops them at the output.
module tb_rr_mux_arbiter;
   localparam int WIDTH = 4;

   typedef struct packed {
      logic [3:0] data;
      logic       last;
      logic [1:0] sel;
   } beat_t;

   logic  clk;
   logic  rst_n;
   int    checks;
   int    errors;
   beat_t sb_q[$];
   logic  pending;

   rr_mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

   rr_mux_arbiter #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   // Monitor: a grant seen before the edge must appear as the next registered beat.
   always begin
      @(negedge clk);
      #3;
      pending = rst_n && (bus.req_ready != 4'b0000);
      @(posedge clk);
      #1;
      if (pending && rst_n) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow: got beat data=%h sel=%0d, required no beat", bus.out_data, bus.out_sel);
         end else begin
            beat_t exp_b;
            exp_b = sb_q.pop_front();
            if ({bus.out_valid, bus.out_data, bus.out_last, bus.out_sel} !== {1'b1, exp_b.data, exp_b.last, exp_b.sel}) begin
               errors++;
               $display("FAIL sb_beat: got v=%b d=%h l=%b s=%0d, required v=1 d=%h l=%b s=%0d",
                        bus.out_valid, bus.out_data, bus.out_last, bus.out_sel, exp_b.data, exp_b.last, exp_b.sel);
            end
         end
      end
   end

   task automatic drive(input logic [3:0] v, input logic [15:0] d, input logic [3:0] l, input logic ordy);
      bus.req_valid = v;
      bus.req_data  = d;
      bus.req_last  = l;
      bus.out_ready = ordy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(4'b0000, 16'h0000, 4'b0000, 1'b1);
      #1;
      checks++;
      if ({bus.out_valid, bus.out_data, bus.out_last, bus.out_sel, bus.req_ready} !== {1'b0, 4'h0, 1'b0, 2'd0, 4'b0000}) begin
         errors++;
         $display("FAIL reset_values: got v=%b d=%h l=%b s=%0d rdy=%b, required all zero",
                  bus.out_valid, bus.out_data, bus.out_last, bus.out_sel, bus.req_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({bus.out_valid, bus.req_ready, bus.out_sel} !== {1'b0, 4'b0000, 2'd0}) begin
            errors++;
            $display("FAIL idle_%0d: got v=%b rdy=%b s=%0d, required v=0 rdy=0000 s=0",
                     c, bus.out_valid, bus.req_ready, bus.out_sel);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_g[5];
      logic [15:0] data;
      exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      data  = 16'hDCBA;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         drive(4'b1111, data, 4'b1111, 1'b1);
         #1;
         checks++;
         if (bus.req_ready !== (4'b0001 << exp_g[c])) begin
            errors++;
            $display("FAIL rr_grant_%0d: got %b, required %b", c, bus.req_ready, 4'b0001 << exp_g[c]);
         end
         sb_q.push_back('{data: data[exp_g[c]*4 +: 4], last: 1'b1, sel: exp_g[c]});
      end
      @(negedge clk);
      drive(4'b0000, 16'h0000, 4'b0000, 1'b1);
   endtask

   task automatic test_lock_packet();
      logic [3:0] pkt[3];
      pkt = '{4'h1, 4'h2, 4'h3};
      @(negedge clk);
      drive(4'b0010, 16'h0090, 4'b0010, 1'b1);
      #1;
      checks++;
      if (bus.req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL lock_pre: got %b, required 0010", bus.req_ready);
      end
      sb_q.push_back('{data: 4'h9, last: 1'b1, sel: 2'd1});
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drive(4'b0111, {4'h0, pkt[c], 4'h8, 4'h7}, {1'b0, (c == 2), 2'b11}, 1'b1);
         #1;
         checks++;
         if (bus.req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL lock_beat_%0d: got %b, required 0100", c, bus.req_ready);
         end
         sb_q.push_back('{data: pkt[c], last: (c == 2), sel: 2'd2});
      end
      @(negedge clk);
      drive(4'b0011, 16'h0087, 4'b0011, 1'b1);
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL lock_after: got %b, required 0001", bus.req_ready);
      end
      sb_q.push_back('{data: 4'h7, last: 1'b1, sel: 2'd0});
      @(negedge clk);
      drive(4'b0000, 16'h0000, 4'b0000, 1'b1);
   endtask

   task automatic test_stall();
      @(negedge clk);
      drive(4'b0010, 16'h0050, 4'b0010, 1'b1);
      #1;
      checks++;
      if (bus.req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL stall_load: got %b, required 0010", bus.req_ready);
      end
      sb_q.push_back('{data: 4'h5, last: 1'b1, sel: 2'd1});
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         drive(4'b1000, 16'h6000, 4'b1000, 1'b0);
         #1;
         checks++;
         if ({bus.req_ready, bus.out_valid, bus.out_data, bus.out_sel} !== {4'b0000, 1'b1, 4'h5, 2'd1}) begin
            errors++;
            $display("FAIL stall_%0d: got rdy=%b v=%b d=%h s=%0d, required rdy=0000 v=1 d=5 s=1",
                     c, bus.req_ready, bus.out_valid, bus.out_data, bus.out_sel);
         end
      end
      @(negedge clk);
      drive(4'b1000, 16'h6000, 4'b1000, 1'b1);
      #1;
      checks++;
      if (bus.req_ready !== 4'b1000) begin
         errors++;
         $display("FAIL stall_release: got %b, required 1000", bus.req_ready);
      end
      sb_q.push_back('{data: 4'h6, last: 1'b1, sel: 2'd3});
      @(negedge clk);
      drive(4'b0000, 16'h0000, 4'b0000, 1'b1);
   endtask

   task automatic test_lock_hold();
      @(negedge clk);
      drive(4'b0010, 16'h0010, 4'b0000, 1'b1);
      #1;
      checks++;
      if (bus.req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL hold_start: got %b, required 0010", bus.req_ready);
      end
      sb_q.push_back('{data: 4'h1, last: 1'b0, sel: 2'd1});
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         drive(4'b1000, 16'hE000, 4'b1000, 1'b1);
         #1;
         checks++;
         if (bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL hold_wait_%0d: got %b, required 0000", c, bus.req_ready);
         end
      end
      @(negedge clk);
      drive(4'b1010, 16'hE020, 4'b1010, 1'b1);
      #1;
      checks++;
      if (bus.req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL hold_resume: got %b, required 0010", bus.req_ready);
      end
      sb_q.push_back('{data: 4'h2, last: 1'b1, sel: 2'd1});
      @(negedge clk);
      drive(4'b1000, 16'hE000, 4'b1000, 1'b1);
      #1;
      checks++;
      if (bus.req_ready !== 4'b1000) begin
         errors++;
         $display("FAIL hold_next: got %b, required 1000", bus.req_ready);
      end
      sb_q.push_back('{data: 4'hE, last: 1'b1, sel: 2'd3});
      @(negedge clk);
      drive(4'b0000, 16'h0000, 4'b0000, 1'b1);
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      drive(4'b0100, 16'h0400, 4'b0000, 1'b1);
      #1;
      checks++;
      if (bus.req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL ar_grant: got %b, required 0100", bus.req_ready);
      end
      sb_q.push_back('{data: 4'h4, last: 1'b0, sel: 2'd2});
      @(negedge clk);
      drive(4'b0100, 16'h0500, 4'b0000, 1'b0);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL ar_held: got v=%b, required 1", bus.out_valid);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.out_valid, bus.out_data, bus.out_sel} !== {1'b0, 4'h0, 2'd0}) begin
         errors++;
         $display("FAIL ar_async: got v=%b d=%h s=%0d, required v=0 d=0 s=0", bus.out_valid, bus.out_data, bus.out_sel);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b1101, 16'h9803, 4'b1111, 1'b1);
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL ar_restart: got %b, required 0001", bus.req_ready);
      end
      sb_q.push_back('{data: 4'h3, last: 1'b1, sel: 2'd0});
      @(negedge clk);
      drive(4'b0000, 16'h0000, 4'b0000, 1'b1);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      pending = 1'b0;
      test_reset();
      test_round_robin();
      test_lock_packet();
      test_stall();
      test_lock_hold();
      test_async_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d beats left, required 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
